// File: rtl/period_scan_ctrl.sv
// period_scan_ctrl
//
// Round-robin scheduler that shares one period-measurement engine across
// NUM_CH sensor inputs. Each channel in turn is selected and allowed to
// settle. The block then measures 2^AVG_LOG2 rising-edge-to-rising-edge
// periods and publishes their truncated average, tagged with the channel id.
// A channel that shows no rising edge for TIMEOUT cycles produces a timeout
// result, so a dead sensor cannot stall the scan.
//
// Optional feature macro: PERIOD_SCAN_CH_MASK_EN
//   When defined, the block gains a ch_mask input (1 = skip that channel).
//   Each channel advance picks the next unmasked channel in wrap order.
//   If every channel is masked, the block stays in IDLE.
//
// Ports:
//   clk           in   system clock
//   rst_n         in   asynchronous active-low reset
//   enable        in   level-sensitive scan enable
//   sig_in        in   [NUM_CH] raw asynchronous sensor inputs
//   ch_mask       in   [NUM_CH] channel skip mask (only with PERIOD_SCAN_CH_MASK_EN)
//   ch_sel        out  channel currently selected for measurement
//   busy          out  high in every state except IDLE
//   result_valid  out  one-cycle pulse when a result is published
//   result_ch     out  channel id of the published result
//   result_period out  averaged period in clk cycles, 0 on timeout
//   timeout_flag  out  high when the published result is a timeout

module period_scan_ctrl #(
  parameter int NUM_CH     = 4,
  parameter int CNT_W      = 16,
  parameter int SETTLE_CYC = 8,
  parameter int TIMEOUT    = 50000,
  parameter int AVG_LOG2   = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic [NUM_CH-1:0]         sig_in,
`ifdef PERIOD_SCAN_CH_MASK_EN
  input  logic [NUM_CH-1:0]         ch_mask,
`endif
  output logic [$clog2(NUM_CH)-1:0] ch_sel,
  output logic                      busy,
  output logic                      result_valid,
  output logic [$clog2(NUM_CH)-1:0] result_ch,
  output logic [CNT_W-1:0]          result_period,
  output logic                      timeout_flag
);

  localparam int CH_W   = $clog2(NUM_CH);
  localparam int ACC_W  = CNT_W + AVG_LOG2;
  localparam int SCNT_W = AVG_LOG2 + 1;

  localparam logic [CNT_W-1:0]  TIMEOUT_C   = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [SCNT_W-1:0] LAST_SAMPLE = SCNT_W'((1 << AVG_LOG2) - 1);
  localparam logic [CH_W-1:0]   LAST_CH     = CH_W'(NUM_CH - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    ARM,
    MEASURE,
    DONE
  } state_t;

  state_t state, state_n;

  logic              sync_ff1, sync_ff2, sync_last;
  logic              rise;
  logic [CNT_W-1:0]  cnt, cnt_inc;
  logic [ACC_W-1:0]  acc, acc_sum;
  logic [SCNT_W-1:0] n_samp;
  logic              cnt_expired, settle_done, last_sample, done_timeout;
  logic              enter_settle, enter_done;
  logic [CH_W-1:0]   adv_start, adv_ch;
  logic              adv_found;

  // Edge detector sits behind the two synchronizer flops. Its latency is
  // fixed, so edge-to-edge spacing equals the true period.
  assign rise = sync_ff2 & ~sync_last;

  // One counter serves three roles. In SETTLE it counts settle cycles.
  // In ARM it counts cycles since ARM was entered. In MEASURE it counts
  // cycles since the last edge. It is restarted at 1 on an edge, so at the
  // next edge it holds exactly the period. It saturates instead of wrapping.
  assign cnt_inc     = (cnt == '1) ? cnt : cnt + 1'b1;
  assign cnt_expired = (cnt >= TIMEOUT_C);
  assign settle_done = (cnt >= SETTLE_LAST);
  assign last_sample = (n_samp == LAST_SAMPLE);
  assign acc_sum     = acc + ACC_W'(cnt);

  assign busy = (state != IDLE);

  // Reaching DONE is a timeout unless it happened on the final sampled edge.
  assign done_timeout = (state == ARM) || !rise;

  assign enter_settle = (state_n == SETTLE) && (state != SETTLE);
  assign enter_done   = (state_n == DONE) && (state != DONE);

  // Search starts at channel 0 when leaving IDLE, otherwise at the channel
  // after the current one (with wrap for non-power-of-two NUM_CH).
  assign adv_start = (state == IDLE) ? '0 :
                     ((ch_sel == LAST_CH) ? '0 : ch_sel + 1'b1);

`ifdef PERIOD_SCAN_CH_MASK_EN
  logic [CH_W:0] adv_sum;

  // Pick the first unmasked channel at or after adv_start in wrap order.
  // The loop runs from the farthest offset down, so the nearest unmasked
  // channel is the last assignment and wins.
  always_comb begin
    adv_found = 1'b0;
    adv_ch    = '0;
    adv_sum   = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      adv_sum = {1'b0, adv_start} + (CH_W+1)'(i);
      if (adv_sum >= (CH_W+1)'(NUM_CH)) begin
        adv_sum = adv_sum - (CH_W+1)'(NUM_CH);
      end
      if (!ch_mask[adv_sum[CH_W-1:0]]) begin
        adv_found = 1'b1;
        adv_ch    = adv_sum[CH_W-1:0];
      end
    end
  end
`else
  assign adv_found = 1'b1;
  assign adv_ch    = adv_start;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state logic. Dropping enable aborts any measurement at once.
  // An edge takes priority over a timeout that expires in the same cycle.
  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (enable && adv_found) state_n = SETTLE;
      end
      SETTLE: begin
        if (!enable)          state_n = IDLE;
        else if (settle_done) state_n = ARM;
      end
      ARM: begin
        if (!enable)          state_n = IDLE;
        else if (rise)        state_n = MEASURE;
        else if (cnt_expired) state_n = DONE;
      end
      MEASURE: begin
        if (!enable) begin
          state_n = IDLE;
        end else if (rise) begin
          if (last_sample) state_n = DONE;
        end else if (cnt_expired) begin
          state_n = DONE;
        end
      end
      DONE: begin
        state_n = (enable && adv_found) ? SETTLE : IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Datapath registers: synchronizer, counter, accumulator, channel select
  // and the held result fields. Entering SETTLE switches the channel and
  // clears the synchronizer history, so the previous channel's level cannot
  // appear as an edge on the new one. Result fields are loaded on the way
  // into DONE, so result_valid is high during the single DONE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_ff1      <= 1'b0;
      sync_ff2      <= 1'b0;
      sync_last     <= 1'b0;
      cnt           <= '0;
      acc           <= '0;
      n_samp        <= '0;
      ch_sel        <= '0;
      result_valid  <= 1'b0;
      result_ch     <= '0;
      result_period <= '0;
      timeout_flag  <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      sync_ff1     <= sig_in[ch_sel];
      sync_ff2     <= sync_ff1;
      sync_last    <= sync_ff2;

      case (state)
        SETTLE: begin
          cnt <= settle_done ? CNT_W'(1) : cnt_inc;
        end
        ARM: begin
          if (rise) begin
            cnt    <= CNT_W'(1);
            acc    <= '0;
            n_samp <= '0;
          end else begin
            cnt <= cnt_inc;
          end
        end
        MEASURE: begin
          if (rise) begin
            cnt    <= CNT_W'(1);
            acc    <= acc_sum;
            n_samp <= n_samp + 1'b1;
          end else begin
            cnt <= cnt_inc;
          end
        end
        default: ;
      endcase

      if (enter_done) begin
        result_valid <= 1'b1;
        result_ch    <= ch_sel;
        if (done_timeout) begin
          result_period <= '0;
          timeout_flag  <= 1'b1;
        end else begin
          result_period <= acc_sum[ACC_W-1:AVG_LOG2];
          timeout_flag  <= 1'b0;
        end
      end

      if (enter_settle) begin
        ch_sel    <= adv_ch;
        sync_ff1  <= 1'b0;
        sync_ff2  <= 1'b0;
        sync_last <= 1'b0;
        cnt       <= '0;
        acc       <= '0;
        n_samp    <= '0;
      end else if (state_n == IDLE) begin
        ch_sel <= '0;
      end
    end
  end

endmodule

// File: doc/period_scan_ctrl.md
Name: period_scan_ctrl

Overview:
- Round-robin scheduler that shares one period-measurement engine across NUM_CH sensor inputs (IR beacon receivers).
- For each channel in turn it:
  - selects the channel and lets it settle,
  - measures 2^AVG_LOG2 consecutive rising-edge-to-rising-edge periods in clk cycles,
  - averages them and publishes one result tagged with the channel id.
- Sits between the raw sensor pins and the beacon-decision logic. A dead channel returns a timeout result rather than stalling the scan.

Parameters:
- NUM_CH, 4, number of sensor inputs scanned (2..16).
- CNT_W, 16, width of the period counter and of result_period.
- SETTLE_CYC, 8, cycles waited after a channel switch before arming.
- TIMEOUT, 50000, max cycles without a rising edge before the channel is declared dead; must be ≤ 2^CNT_W-1.
- AVG_LOG2, 2, log2 of the number of periods averaged per result (0..4).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  scan enable; level-sensitive.
- sig_in  in  NUM_CH  raw asynchronous sensor inputs.
- ch_sel  out  clog2(NUM_CH)  channel currently being measured.
- busy  out  1  high in every state except IDLE.
- result_valid  out  1  single-cycle pulse; result fields valid this cycle.
- result_ch  out  clog2(NUM_CH)  channel id of the result.
- result_period  out  CNT_W  averaged period in clk cycles; 0 on timeout.
- timeout_flag  out  1  high with result_valid when the result is a timeout.

Behaviour:
- Reset (rst_n low, async):
  - State is IDLE.
  - ch_sel, result_ch, result_period, accumulator and counters are 0.
  - busy, result_valid and timeout_flag are 0.
  - Synchronizer flops are 0.
- Input path:
  - The selected sig_in bit passes through a 2-flop synchronizer, then a rising-edge detector (sync & ~sync_last).
  - Total latency is constant, 2 cycles, so periods are unaffected.
- States: IDLE, SETTLE, ARM, MEASURE, DONE.
  - IDLE: while enable=0, hold ch_sel=0. When enable=1, go to SETTLE next cycle.
  - SETTLE: count SETTLE_CYC cycles, ignoring edges, then go to ARM. Synchronizer history is cleared on entry so no false edge is seen from the previous channel.
  - ARM: wait for the first rising edge; on it, clear the period counter and enter MEASURE.
  - MEASURE:
    - Period counter increments each cycle.
    - On each rising edge, add the sample (edges at cycles t and t+D give sample D) to the accumulator and restart the counter.
    - After 2^AVG_LOG2 samples, go to DONE.
  - Timeout: in ARM or MEASURE, if the cycles since entering ARM or since the last edge reach TIMEOUT, go to DONE with the timeout condition.
  - DONE (1 cycle):
    - Assert result_valid and set result_ch=ch_sel.
    - Normal: result_period = accumulator >> AVG_LOG2 (truncating), timeout_flag=0.
    - Timeout: result_period=0, timeout_flag=1.
    - Advance ch_sel by 1, wrapping NUM_CH-1 to 0, then go to SETTLE if enable=1, else IDLE.
- Widths:
  - Accumulator is CNT_W+AVG_LOG2 bits.
  - Samples saturate at 2^CNT_W-1 and never wrap.
- Result hold: result_ch, result_period and timeout_flag hold their last values between pulses. result_valid is high for exactly 1 cycle per completed channel.
- Enable deasserted in SETTLE, ARM or MEASURE: next cycle go to IDLE, discard the partial measurement, emit no result_valid, set ch_sel=0.
- Edge coincident with timeout: the edge wins; the sample is taken and the timeout counter restarts.
- Reset mid-operation: immediate return to reset values; no result pulse.

Optional Feature:
- Macro: PERIOD_SCAN_CH_MASK_EN.
- Defined: adds input ch_mask [NUM_CH] (1 = skip channel).
  - Channel advance (from IDLE exit or DONE) picks the next unmasked channel in wrap order.
  - If all channels are masked, the block stays in or returns to IDLE with busy=0 and emits no results.
  - ch_mask is sampled at the channel advance only.
- Not defined: no ch_mask port; all channels are scanned.

Test Plan:
- Default params, enable=1, sig_in[0] square wave, period 100 cycles -> result_valid with result_ch=0, result_period=100, timeout_flag=0; ch_sel then becomes 1.
- ch0 periods 98,102,99,101 (AVG_LOG2=2) -> result_period=100. Periods 100,100,100,101 -> result_period=100 (truncation).
- TIMEOUT=1000, sig_in[1] held low -> about 8+1000 cycles after entering SETTLE: result_ch=1, result_period=0, timeout_flag=1; scan continues to ch2.
- All 4 channels driven with periods 50/60/70/80 -> results in order ch0..ch3 then ch0 again, values 50/60/70/80, each result_valid exactly 1 cycle.
- enable dropped mid-MEASURE on ch2 -> no result_valid, IDLE next cycle, busy=0, ch_sel=0. Re-enable -> scan restarts at ch0. rst_n pulsed mid-MEASURE -> all outputs 0 immediately.
- With PERIOD_SCAN_CH_MASK_EN, ch_mask=4'b1010 -> results only for ch0 and ch2 alternately. ch_mask=4'b1111 -> busy stays 0, no result_valid.
